// File: rtl/wb2axi4l_bridge.sv
// Wishbone classic slave to AXI4-Lite master bridge, one transaction in flight.
// Ports: wb_* Wishbone slave side, m_axi_* AXI4-Lite master side, single clock.
//
// Each Wishbone cycle is turned into exactly one AXI4-Lite read or write.
// Request fields are latched in IDLE and held until the AXI side completes,
// so AXI address/data/strobe stay stable while any valid is high.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wb_adr_i/dat_i/sel_i/we_i Wishbone request
//   wb_cyc_i, wb_stb_i        Wishbone cycle qualifiers
//   wb_dat_o, wb_ack_o,
//   wb_err_o                  Wishbone response (ack/err are 1-cycle pulses)
//   m_axi_aw*/w*/b*           AXI4-Lite write channels
//   m_axi_ar*/r*              AXI4-Lite read channels
module wb2axi4l_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [3:0]              sel_q, sel_d;
  logic                    aw_q, aw_d;
  logic                    w_q, w_d;
  logic                    err_q, err_d;
  logic                    abort_q, abort_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic req;
  assign req = wb_cyc_i & wb_stb_i;

  // State and datapath registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      aw_q    <= 1'b0;
      w_q     <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      aw_q    <= aw_d;
      w_q     <= w_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    aw_d    = aw_q;
    w_d     = w_q;
    err_d   = err_q;
    abort_d = abort_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (req) begin
          adr_d = wb_adr_i;
          dat_d = wb_dat_i;
          sel_d = wb_sel_i;
          if (wb_we_i) begin
            aw_d    = 1'b1;
            w_d     = 1'b1;
            state_d = WADDR;
          end else begin
            state_d = RADDR;
          end
        end
      end
      WADDR: begin
        // AW and W complete independently; leave once both are done,
        // which also covers both readies in the same cycle.
        if (aw_q && m_axi_awready) aw_d = 1'b0;
        if (w_q && m_axi_wready)   w_d  = 1'b0;
        if (!aw_d && !w_d)         state_d = WRESP;
      end
      WRESP: begin
        if (m_axi_bvalid) begin
          err_d   = m_axi_bresp[1];
          state_d = DONE;
        end
      end
      RADDR: begin
        if (m_axi_arready) state_d = RDATA;
      end
      RDATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          err_d   = m_axi_rresp[1];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A master that lets go mid-transaction loses its response,
    // but the AXI side is still run to completion.
    if (state_q != IDLE && !req) abort_d = 1'b1;
  end

  // Output logic
  always_comb begin
    m_axi_awvalid = aw_q;
    m_axi_wvalid  = w_q;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    wb_ack_o      = 1'b0;
    wb_err_o      = 1'b0;

    unique case (state_q)
      WRESP: m_axi_bready  = 1'b1;
      RADDR: m_axi_arvalid = 1'b1;
      RDATA: m_axi_rready  = 1'b1;
      DONE: begin
        if (!abort_q && req) begin
          wb_ack_o = !err_q;
          wb_err_o = err_q;
        end
      end
      default: ;
    endcase
  end

  assign m_axi_awaddr = adr_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_wdata  = dat_q;
  assign m_axi_wstrb  = sel_q;
  assign m_axi_araddr = adr_q;
  assign m_axi_arprot = 3'b000;
  assign wb_dat_o     = rdata_q;

endmodule

// File: tb/tb_wb2axi4l_bridge.sv
// Self-checking bench for wb2axi4l_bridge.
// Table of directed transactions against a delay-programmable AXI slave.
module tb_wb2axi4l_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  always #5 clk = ~clk;

  wb2axi4l_bridge dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wb_adr_i      (wb_adr),
    .wb_dat_i      (wb_dat_w),
    .wb_sel_i      (wb_sel),
    .wb_we_i       (wb_we),
    .wb_cyc_i      (wb_cyc),
    .wb_stb_i      (wb_stb),
    .wb_dat_o      (wb_dat_r),
    .wb_ack_o      (wb_ack),
    .wb_err_o      (wb_err),
    .m_axi_awaddr  (awaddr),
    .m_axi_awprot  (awprot),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .m_axi_araddr  (araddr),
    .m_axi_arprot  (arprot),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  resp;
    logic [31:0] rd;
    int          exp_ack, exp_err, exp_lat;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[7];

  int n_chk = 0;
  int n_fail = 0;

  // slave model state
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [1:0]  s_resp;
  logic [31:0] s_rdata;
  bit          aw_done, w_done, ar_done, r_done;
  bit          pre_awv, pre_wv, pre_br, pre_arv, pre_rr;
  bit          hs_aw, hs_w, hs_ar, hs_r;
  bit          prev_aw_pend, prev_w_pend, prev_ar_pend;
  logic [31:0] prev_awaddr, prev_araddr;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  int          viol;

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic we, logic [31:0] adr, logic [31:0] dat,
                              logic [3:0] sel, int awd, int wd, int bd,
                              int ard, int rd_d, logic [1:0] resp,
                              logic [31:0] rd, int ea, int ee, int el,
                              logic [31:0] ed);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel;
    v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd;
    v.ar_dly = ard; v.r_dly = rd_d;
    v.resp = resp; v.rd = rd;
    v.exp_ack = ea; v.exp_err = ee; v.exp_lat = el; v.exp_dat = ed;
    return v;
  endfunction

  task automatic slave_cfg(int awd, int wd, int bd, int ard, int rdd,
                           logic [1:0] resp, logic [31:0] rd);
    aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rdd;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    s_resp = resp; s_rdata = rd;
    aw_done = 0; w_done = 0; ar_done = 0; r_done = 0;
    prev_aw_pend = 0; prev_w_pend = 0; prev_ar_pend = 0;
    cap_awaddr = '1; cap_wdata = '1; cap_araddr = '1; cap_wstrb = '1;
    viol = 0;
  endtask

  // Called just after a rising edge: protocol checks, then drive readies.
  task automatic slave_drive();
    if (awvalid && aw_done) viol++;
    if (wvalid && w_done) viol++;
    if (bready && !(aw_done && w_done)) viol++;
    if (rready && !ar_done) viol++;
    if (awprot != 3'b0 || arprot != 3'b0) viol++;
    if (wb_ack && wb_err) viol++;
    if (prev_aw_pend && (!awvalid || awaddr != prev_awaddr)) viol++;
    if (prev_ar_pend && (!arvalid || araddr != prev_araddr)) viol++;
    if (prev_w_pend && !wvalid) viol++;
    awready = awvalid && (aw_cnt >= aw_dly);
    wready  = wvalid && (w_cnt >= w_dly);
    arready = arvalid && (ar_cnt >= ar_dly);
    bvalid  = bready && (b_cnt >= b_dly);
    bresp   = bvalid ? s_resp : 2'b00;
    rvalid  = rready && (r_cnt >= r_dly);
    rresp   = rvalid ? s_resp : 2'b00;
    rdata   = rvalid ? s_rdata : 32'h0;
    pre_awv = awvalid; pre_wv = wvalid; pre_br = bready;
    pre_arv = arvalid; pre_rr = rready;
    hs_aw = awvalid && awready;
    hs_w  = wvalid && wready;
    hs_ar = arvalid && arready;
    hs_r  = rready && rvalid;
    if (hs_aw) cap_awaddr = awaddr;
    if (hs_w) begin cap_wdata = wdata; cap_wstrb = wstrb; end
    if (hs_ar) cap_araddr = araddr;
    prev_aw_pend = awvalid && !awready;
    prev_w_pend  = wvalid && !wready;
    prev_ar_pend = arvalid && !arready;
    prev_awaddr  = awaddr;
    prev_araddr  = araddr;
  endtask

  task automatic slave_update();
    if (pre_awv) aw_cnt++;
    if (pre_wv)  w_cnt++;
    if (pre_br)  b_cnt++;
    if (pre_arv) ar_cnt++;
    if (pre_rr)  r_cnt++;
    if (hs_aw) aw_done = 1;
    if (hs_w)  w_done = 1;
    if (hs_ar) ar_done = 1;
    if (hs_r)  r_done = 1;
  endtask

  task automatic tick();
    slave_drive();
    @(posedge clk);
    #1;
    slave_update();
  endtask

  task automatic run(string nm, vec_t v);
    int lat, nack, nerr;
    bit got;
    logic [31:0] dat_at;
    slave_cfg(v.aw_dly, v.w_dly, v.b_dly, v.ar_dly, v.r_dly, v.resp, v.rd);
    wb_adr = v.adr; wb_dat_w = v.dat; wb_sel = v.sel; wb_we = v.we;
    wb_cyc = 1; wb_stb = 1;
    lat = 0; nack = 0; nerr = 0; got = 0; dat_at = '1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (got) begin wb_cyc = 0; wb_stb = 0; end
      if (wb_ack || wb_err) begin
        if (!got) begin lat = c; dat_at = wb_dat_r; end
        got = 1;
        nack += int'(wb_ack);
        nerr += int'(wb_err);
      end
      if (got && c >= lat + 3) break;
    end
    wb_cyc = 0; wb_stb = 0;
    chk({nm, " ack count"}, nack, v.exp_ack);
    chk({nm, " err count"}, nerr, v.exp_err);
    chk({nm, " latency"}, lat, v.exp_lat);
    chk({nm, " wb_dat_o"}, dat_at, v.exp_dat);
    chk({nm, " protocol"}, viol, 0);
    if (v.we) begin
      chk({nm, " awaddr"}, cap_awaddr, v.adr);
      chk({nm, " wdata"}, cap_wdata, v.dat);
      chk({nm, " wstrb"}, cap_wstrb, v.sel);
    end else begin
      chk({nm, " araddr"}, cap_araddr, v.adr);
    end
  endtask

  function automatic logic any_out();
    return |{wb_dat_r, wb_ack, wb_err, awaddr, awprot, awvalid, wdata,
             wstrb, wvalid, bready, araddr, arprot, arvalid, rready};
  endfunction

  initial begin
    int nack, nerr, a1, a2, av;
    bit seen;
    //             we adr           dat           sel  aw w b ar r resp  rdata         ack err lat dat_o
    tbl[0] = mk(1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,        1, 0, 3, 32'h0);
    tbl[1] = mk(0, 32'h0000_2004, 32'h0,         4'hF, 0, 0, 0, 2, 3, 2'b00, 32'hCAFE_F00D, 1, 0, 8, 32'hCAFE_F00D);
    tbl[2] = mk(1, 32'h0000_3008, 32'h1234_5678, 4'h5, 4, 0, 0, 0, 0, 2'b00, 32'h0,        1, 0, 7, 32'hCAFE_F00D);
    tbl[3] = mk(0, 32'h0000_4000, 32'h0,         4'hF, 0, 0, 0, 0, 0, 2'b10, 32'h55AA_55AA, 0, 1, 3, 32'h55AA_55AA);
    tbl[4] = mk(1, 32'h0000_5003, 32'hFFFF_0000, 4'h0, 0, 0, 0, 0, 0, 2'b01, 32'h0,        1, 0, 3, 32'h55AA_55AA);
    tbl[5] = mk(1, 32'h0000_6000, 32'h0BAD_F00D, 4'h3, 0, 3, 2, 0, 0, 2'b11, 32'h0,        0, 1, 8, 32'h55AA_55AA);
    tbl[6] = mk(0, 32'h0000_7010, 32'h0,         4'hF, 0, 0, 0, 0, 1, 2'b01, 32'h0BAD_CAFE, 1, 0, 4, 32'h0BAD_CAFE);

    rst = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0;
    wb_adr = 0; wb_dat_w = 0; wb_sel = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    slave_cfg(0, 0, 0, 0, 0, 2'b00, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", any_out(), 0);
    rst = 0;
    tick();

    for (int i = 0; i < 7; i++) run($sformatf("vec%0d", i), tbl[i]);

    // Master drops stb while the read data phase is pending.
    slave_cfg(0, 0, 0, 0, 3, 2'b00, 32'hA5A5_0001);
    wb_adr = 32'h0000_8000; wb_we = 0; wb_sel = 4'hF;
    wb_cyc = 1; wb_stb = 1;
    nack = 0; nerr = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (rready) begin wb_stb = 0; wb_cyc = 0; end
      nack += int'(wb_ack);
      nerr += int'(wb_err);
    end
    chk("abort ack", nack, 0);
    chk("abort err", nerr, 0);
    chk("abort read done", r_done, 1);
    chk("abort wb_dat_o", wb_dat_r, 32'hA5A5_0001);
    chk("abort protocol", viol, 0);
    run("after abort", mk(0, 32'h0000_8004, 0, 4'hF, 0, 0, 0, 1, 0, 2'b00,
                          32'h1357_9BDF, 1, 0, 4, 32'h1357_9BDF));

    // Back-to-back reads with stb held: one IDLE cycle between ack and arvalid.
    slave_cfg(0, 0, 0, 0, 0, 2'b00, 32'h2468_ACE0);
    wb_adr = 32'h0000_9000; wb_we = 0; wb_cyc = 1; wb_stb = 1;
    a1 = 0; a2 = 0; av = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (a1 != 0 && av == 0 && arvalid) av = c;
      if (wb_ack) begin
        if (a1 == 0) a1 = c;
        else if (a2 == 0) a2 = c;
      end
      if (a2 != 0) begin wb_cyc = 0; wb_stb = 0; break; end
    end
    chk("b2b first ack", a1, 3);
    chk("b2b next arvalid", av, 5);
    chk("b2b second ack", a2, 7);
    tick();
    tick();

    // Reset while waiting for the write response.
    slave_cfg(0, 0, 5, 0, 0, 2'b00, 32'h0);
    wb_adr = 32'h0000_A000; wb_dat_w = 32'h1111_2222; wb_sel = 4'hF;
    wb_we = 1; wb_cyc = 1; wb_stb = 1;
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bready) begin seen = 1; break; end
    end
    chk("reached WRESP", seen, 1);
    rst = 1;
    tick();
    chk("mid-txn reset outputs", any_out(), 0);
    rst = 0; wb_cyc = 0; wb_stb = 0;
    tick();
    chk("post reset idle", any_out(), 0);
    run("read after reset", mk(0, 32'h0, 0, 4'hF, 0, 0, 0, 0, 0, 2'b00,
                               32'h0F0F_F0F0, 1, 0, 3, 32'h0F0F_F0F0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
